// File: rtl/servo_pwm_gen.sv
// Double-buffered servo PWM generator; set-points take effect only at a period wrap.
// pwm_out is a registered compare, one clk behind the counter; there is no backpressure.
module servo_pwm_gen #(
   parameter int TICK_DIV = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load,
   input  logic [11:0] dutty,
   input  logic [19:0] period,
   output logic        pwm_out,
   output logic        period_done,
   output logic        update_ack,
   output logic        pending,
   output logic [7:0]  cycle_cnt
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [11:0]   p_duty, a_duty;
   logic [19:0]   p_per, a_per;
   logic [PW-1:0] pre;
   logic [19:0]   cnt;
   logic          tick, wrap, keep_run, do_apply;

   always_comb begin
      tick     = (pre == PRE_MAX);
      wrap     = tick && (cnt == a_per - 20'd1);
      keep_run = en && (a_per != 20'd0);
      // IDLE applies whenever something is pending; RUN only on a real wrap.
      do_apply = pending && ((state == IDLE) || (keep_run && wrap));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         p_duty      <= '0;
         p_per       <= '0;
         a_duty      <= '0;
         a_per       <= '0;
         pre         <= '0;
         cnt         <= '0;
         pwm_out     <= 1'b0;
         period_done <= 1'b0;
         update_ack  <= 1'b0;
         pending     <= 1'b0;
         cycle_cnt   <= '0;
      end else begin
         period_done <= 1'b0;
         update_ack  <= 1'b0;
         pwm_out     <= (state == RUN) && (cnt < {8'd0, a_duty});

         if (do_apply) begin
            a_duty     <= p_duty;
            a_per      <= p_per;
            update_ack <= 1'b1;
            pending    <= 1'b0;
         end
         // A capture in the apply clk stays pending: the apply above used the old pair.
         if (load) begin
            p_duty  <= dutty;
            p_per   <= period;
            pending <= 1'b1;
         end

         case (state)
            IDLE: begin
               pre <= '0;
               cnt <= '0;
               if (keep_run) state <= RUN;
            end
            RUN: begin
               if (!keep_run) begin
                  state <= IDLE;
                  pre   <= '0;
                  cnt   <= '0;
               end else if (tick) begin
                  pre <= '0;
                  if (wrap) begin
                     cnt         <= '0;
                     period_done <= 1'b1;
                     cycle_cnt   <= cycle_cnt + 8'd1;
                  end else begin
                     cnt <= cnt + 20'd1;
                  end
               end else begin
                  pre <= pre + PW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
